upct_nway: RTL and testbench
============================

Name: upct_nway

Overview:
- Upper-PC table (UPCT) with a parametrised entry count and a tree-PLRU replacement policy.
- Generalises the current fixed 8-entry UPCT.
- Stores the upper bits of branch targets so that the BTB only needs to hold 11-bit low targets plus a small UPCT index.
- Sits beside the BTB in fetch: fetch reads by index; branch-resolution updates install or refresh a full target and return the index to store in the BTB.

Parameters:
- UPCT_ENTRIES, 8: table depth; power of 2, at least 2.
- LOG_UPCT_ENTRIES, $clog2(UPCT_ENTRIES): index width.
- UPPER_PC_WIDTH, 20: stored upper-PC bits, PC[31:32-UPPER_PC_WIDTH].

Ports:
- CLK  input  1  clock
- rst  input  1  synchronous active-high reset
- read_index  input  LOG_UPCT_ENTRIES  fetch lookup index
- read_upper_PC  output  UPPER_PC_WIDTH  upper PC for read_index; registered, 1-cycle latency
- update0_valid  input  1  update request
- update0_target_full_PC  input  32  resolved target PC
- update1_valid  output  1  registered update0_valid
- update1_upct_index  output  LOG_UPCT_ENTRIES  index holding the target's upper PC
- update1_hit  output  1  upper PC was already present

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (rst).
- Reset: all valid bits 0, all upper-PC entries 0, all PLRU bits 0. read_upper_PC, update1_valid, update1_upct_index and update1_hit all reset to 0.
- Read: read_upper_PC <= array[read_index] on every edge. No valid check. Reads do not touch PLRU.
- Update stage 0 (cycle N):
  - Compare the upper bits of update0_target_full_PC against every valid entry (CAM).
  - Also compare against the stage-1 pending write (forwarding).
  - Register into stage 1: the match result, the matching index, and the upper PC.
- Update stage 1 (cycle N+1):
  - On hit: update1_hit=1, index = matching entry, no array write.
  - On miss, victim selection: the lowest-indexed invalid entry if any exists; otherwise the PLRU victim. Write the upper PC into the victim and set its valid bit. update1_hit=0.
  - In both cases, touch the PLRU with the chosen index. update1_valid=1 and update1_upct_index = chosen index.
  - All writes take effect at the edge ending N+1.
- Tree PLRU:
  - UPCT_ENTRIES-1 node bits in heap order (node 0 is root; children 2k+1 and 2k+2).
  - Node bit 0 means the victim lies in the lower-index subtree; bit 1 means the higher-index subtree.
  - Touch sets every node on the path to point away from the touched leaf.
- Back-to-back updates with the same upper PC (N, N+1):
  - The cycle N+1 stage-0 compare must hit the stage-1 pending write (forwarding).
  - Result: update1_hit=1 with the same index; no duplicate entry is created.
- Read/write same index in the same cycle: read_upper_PC shows the newly written value (write bypass).
- Table full, all valid: only PLRU replacement is used. With 8 entries and no hits, victims cycle through all entries before any repeats.
- rst asserted mid-update: the stage-1 write is dropped and everything returns to reset values.
- update0_valid=0: stage 1 does not write or touch, and update1_valid=0.

Optional Feature:
- Macro: UPCT_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_hit_count and perf_miss_count, each 32 bits.
  - Each increments on a valid stage-1 hit or miss respectively, saturating at 32'hFFFFFFFF.
  - Both reset to 0.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Add to the core types package:
  - UPCT_ENTRIES, LOG_UPCT_ENTRIES, UPPER_PC_WIDTH (existing names).
  - UPCT_PLRU_BITS = UPCT_ENTRIES-1.
- Replace the "constant 8" note with the power-of-2 constraint.
- Natural sub-module: plru_tree.
  - Parameter: ENTRIES.
  - Function: combinational victim from the current bits, plus the next-state bits for a touch index.
  - Reusable by BTB and TLB.

Test Plan:
- Reset, then 8 misses (UPCT_ENTRIES=8) with upper PCs 0x00001..0x00008 -> indices 0..7 in order, update1_hit=0 each.
- After table full, update with 0x00003 -> hit, index 2. Next miss 0x00009 -> PLRU victim per tree with node bits recomputed; bench model must match index.
- Back-to-back updates PC 0xABCDE000 in cycles N and N+1 (new) -> both index 0; first hit=0, second hit=1; only one valid entry.
- Write of index 5 during cycle N+1 with read_index=5 -> read_upper_PC equals new value the following cycle.
- UPCT_ENTRIES=16: 16 distinct misses then a 17th -> victim index 0 (PLRU after sequential fill), read of index 0 returns the 17th value.
- UPCT_PERF_CNT_EN defined: 3 misses then 2 hits -> perf_miss_count=3, perf_hit_count=2. Assert rst -> both 0.

Source files
------------

// File: rtl/upct_nway_pkg.sv
// Shared constants and helpers for the upper-PC table.
// Table depth must be a power of two and at least 2.
package upct_nway_pkg;

    localparam int UPCT_ENTRIES     = 8;
    localparam int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES);
    localparam int UPPER_PC_WIDTH   = 20;
    localparam int UPCT_PLRU_BITS   = UPCT_ENTRIES - 1;

    // Node count of a full binary PLRU tree over the given number of leaves.
    function automatic int plru_bits(input int entries);
        return entries - 1;
    endfunction

endpackage

// File: rtl/upct_nway_plru_tree.sv
// Tree-PLRU helper: combinational victim and post-touch node bits.
// Heap-ordered nodes; a node bit of 1 points the victim at the higher-index subtree.
module upct_nway_plru_tree
    import upct_nway_pkg::*;
#(
    parameter int ENTRIES = UPCT_ENTRIES,
    localparam int LOG_ENTRIES = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-2:0]     bits_i,
    input  logic [LOG_ENTRIES-1:0] touch_idx_i,
    output logic [LOG_ENTRIES-1:0] victim_o,
    output logic [ENTRIES-2:0]     bits_next_o
);

    always_comb begin
        int node;
        victim_o = '0;
        node     = 0;
        for (int lvl = 0; lvl < LOG_ENTRIES; lvl++) begin
            victim_o[LOG_ENTRIES-1-lvl] = bits_i[LOG_ENTRIES'(node)];
            node = 2 * node + 1 + int'(bits_i[LOG_ENTRIES'(node)]);
        end
    end

    // Each node on the touched path is flipped to point away from the touched leaf.
    always_comb begin
        int   node;
        logic dir;
        bits_next_o = bits_i;
        node        = 0;
        for (int lvl = 0; lvl < LOG_ENTRIES; lvl++) begin
            dir = touch_idx_i[LOG_ENTRIES-1-lvl];
            bits_next_o[LOG_ENTRIES'(node)] = ~dir;
            node = 2 * node + 1 + int'(dir);
        end
    end

endmodule

// File: rtl/upct_nway.sv
// Upper-PC table with CAM install/refresh, stage-1 forwarding and tree-PLRU replacement.
// Optional hit/miss performance counters are enabled with the UPCT_PERF_CNT_EN macro.
module upct_nway
    import upct_nway_pkg::*;
#(
    parameter int UPCT_ENTRIES     = upct_nway_pkg::UPCT_ENTRIES,
    parameter int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES),
    parameter int UPPER_PC_WIDTH   = upct_nway_pkg::UPPER_PC_WIDTH
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic [LOG_UPCT_ENTRIES-1:0] read_index,
    output logic [UPPER_PC_WIDTH-1:0]   read_upper_PC,
    input  logic                        update0_valid,
    input  logic [31:0]                 update0_target_full_PC,
    output logic                        update1_valid,
    output logic [LOG_UPCT_ENTRIES-1:0] update1_upct_index,
`ifdef UPCT_PERF_CNT_EN
    output logic [31:0]                 perf_hit_count,
    output logic [31:0]                 perf_miss_count,
`endif
    output logic                        update1_hit
);

    localparam int LOG = LOG_UPCT_ENTRIES;
    localparam int W   = UPPER_PC_WIDTH;
    localparam int NB  = plru_bits(UPCT_ENTRIES);

    logic [W-1:0]            upper_q [UPCT_ENTRIES];
    logic [UPCT_ENTRIES-1:0] valid_q;
    logic [NB-1:0]           plru_q, plru_d, plru_touched;
    logic [W-1:0]            read_q, read_d;

    logic           s1_valid_q, s1_valid_d;
    logic           s1_hit_q, s1_hit_d;
    logic [LOG-1:0] s1_idx_q, s1_idx_d;
    logic [W-1:0]   s1_upper_q, s1_upper_d;

    logic [W-1:0]   upper0;
    logic           cam_hit, fwd_hit;
    logic [LOG-1:0] cam_idx;
    logic           inv_found;
    logic [LOG-1:0] inv_idx, plru_victim, chosen_idx;
    logic           wr_en;
    logic           unused_low_pc;

    assign upper0        = update0_target_full_PC[31 -: W];
    assign unused_low_pc = ^update0_target_full_PC[31-W:0];

    upct_nway_plru_tree #(
        .ENTRIES(UPCT_ENTRIES)
    ) u_plru (
        .bits_i      (plru_q),
        .touch_idx_i (chosen_idx),
        .victim_o    (plru_victim),
        .bits_next_o (plru_touched)
    );

    // Lowest-indexed invalid entry is preferred over the PLRU victim.
    always_comb begin
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = UPCT_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_found = 1'b1;
                inv_idx   = LOG'(i);
            end
        end
    end

    always_comb begin
        chosen_idx = plru_victim;
        if (s1_hit_q) begin
            chosen_idx = s1_idx_q;
        end else if (inv_found) begin
            chosen_idx = inv_idx;
        end
        wr_en  = s1_valid_q && !s1_hit_q;
        plru_d = s1_valid_q ? plru_touched : plru_q;
    end

    // The entry being overwritten this cycle must not be reported as a hit on its old value.
    always_comb begin
        cam_hit = 1'b0;
        cam_idx = '0;
        for (int i = 0; i < UPCT_ENTRIES; i++) begin
            if (valid_q[i] && (upper_q[i] == upper0) &&
                !(wr_en && (chosen_idx == LOG'(i)))) begin
                cam_hit = 1'b1;
                cam_idx = LOG'(i);
            end
        end
        fwd_hit = wr_en && (s1_upper_q == upper0);
    end

    always_comb begin
        s1_valid_d = update0_valid;
        s1_hit_d   = update0_valid && (cam_hit || fwd_hit);
        s1_idx_d   = fwd_hit ? chosen_idx : cam_idx;
        s1_upper_d = upper0;
    end

    always_comb begin
        read_d = upper_q[read_index];
        if (wr_en && (chosen_idx == read_index)) begin
            read_d = s1_upper_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < UPCT_ENTRIES; i++) begin
                upper_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (wr_en) begin
            upper_q[chosen_idx] <= s1_upper_q;
            valid_q[chosen_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            plru_q     <= '0;
            read_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_upper_q <= '0;
        end else begin
            plru_q     <= plru_d;
            read_q     <= read_d;
            s1_valid_q <= s1_valid_d;
            s1_hit_q   <= s1_hit_d;
            s1_idx_q   <= s1_idx_d;
            s1_upper_q <= s1_upper_d;
        end
    end

    assign read_upper_PC      = read_q;
    assign update1_valid      = s1_valid_q;
    assign update1_hit        = s1_valid_q && s1_hit_q;
    assign update1_upct_index = s1_valid_q ? chosen_idx : '0;

`ifdef UPCT_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating counters so long runs never wrap back to small values.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (s1_valid_q && s1_hit_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (s1_valid_q && !s1_hit_q && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign perf_hit_count  = hit_cnt_q;
    assign perf_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_upct_nway.sv
// Directed bench for upct_nway: an 8-entry and a 16-entry instance share clock and reset.
// Counter checks run only when UPCT_PERF_CNT_EN is defined.
module tb_upct_nway;

    logic        clk;
    logic        rst;

    logic [2:0]  rd_idx8;
    logic [19:0] rd8;
    logic        v0_8;
    logic [31:0] pc8;
    logic        v1_8;
    logic [2:0]  idx1_8;
    logic        hit1_8;

    logic [3:0]  rd_idx16;
    logic [19:0] rd16;
    logic        v0_16;
    logic [31:0] pc16;
    logic        v1_16;
    logic [3:0]  idx1_16;
    logic        hit1_16;

    int checks;
    int failures;

`ifdef UPCT_PERF_CNT_EN
    logic [31:0] phit8, pmiss8, phit16, pmiss16;
`endif

    upct_nway u8 (
        .CLK                    (clk),
        .rst                    (rst),
        .read_index             (rd_idx8),
        .read_upper_PC          (rd8),
        .update0_valid          (v0_8),
        .update0_target_full_PC (pc8),
        .update1_valid          (v1_8),
        .update1_upct_index     (idx1_8),
`ifdef UPCT_PERF_CNT_EN
        .perf_hit_count         (phit8),
        .perf_miss_count        (pmiss8),
`endif
        .update1_hit            (hit1_8)
    );

    upct_nway #(
        .UPCT_ENTRIES(16)
    ) u16 (
        .CLK                    (clk),
        .rst                    (rst),
        .read_index             (rd_idx16),
        .read_upper_PC          (rd16),
        .update0_valid          (v0_16),
        .update0_target_full_PC (pc16),
        .update1_valid          (v1_16),
        .update1_upct_index     (idx1_16),
`ifdef UPCT_PERF_CNT_EN
        .perf_hit_count         (phit16),
        .perf_miss_count        (pmiss16),
`endif
        .update1_hit            (hit1_16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        rst   = 1'b1;
        v0_8  = 1'b0;
        v0_16 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One update through stage 0; returns the stage-1 outputs of the following cycle.
    task automatic drive8(input logic [31:0] pc, output logic v, output logic [2:0] idx,
                          output logic h);
        v0_8 = 1'b1;
        pc8  = pc;
        @(posedge clk);
        #1;
        v0_8 = 1'b0;
        v    = v1_8;
        idx  = idx1_8;
        h    = hit1_8;
    endtask

    task automatic drive16(input logic [31:0] pc, output logic v, output logic [3:0] idx,
                           output logic h);
        v0_16 = 1'b1;
        pc16  = pc;
        @(posedge clk);
        #1;
        v0_16 = 1'b0;
        v     = v1_16;
        idx   = idx1_16;
        h     = hit1_16;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        v0_8     = 1'b0;
        v0_16    = 1'b0;
        pc8      = 32'hFFFF_FFFF;
        pc16     = 32'hFFFF_FFFF;
        rd_idx8  = 3'd0;
        rd_idx16 = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({v1_8, idx1_8, hit1_8, rd8} !== 25'd0) begin
            failures++;
            $display("FAIL reset8: valid=%0b idx=%0d hit=%0b rd=%h, required all 0",
                     v1_8, idx1_8, hit1_8, rd8);
        end
        checks++;
        if ({v1_16, idx1_16, hit1_16, rd16} !== 26'd0) begin
            failures++;
            $display("FAIL reset16: valid=%0b idx=%0d hit=%0b rd=%h, required all 0",
                     v1_16, idx1_16, hit1_16, rd16);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill_and_plru();
        logic       v, h;
        logic [2:0] idx;
        for (int i = 0; i < 8; i++) begin
            drive8(32'(i + 1) << 12, v, idx, h);
            checks++;
            if ({v, idx, h} !== {1'b1, 3'(i), 1'b0}) begin
                failures++;
                $display("FAIL fill8[%0d]: valid=%0b idx=%0d hit=%0b, required valid=1 idx=%0d hit=0",
                         i, v, idx, h, i);
            end
        end
        drive8(32'h0000_3000, v, idx, h);
        checks++;
        if ({v, idx, h} !== {1'b1, 3'd2, 1'b1}) begin
            failures++;
            $display("FAIL hit_full: valid=%0b idx=%0d hit=%0b, required valid=1 idx=2 hit=1",
                     v, idx, h);
        end
        // After the fill every node is 0; touching 2 sets nodes 0 and 4, so the victim is 4.
        drive8(32'h0000_9000, v, idx, h);
        checks++;
        if ({v, idx, h} !== {1'b1, 3'd4, 1'b0}) begin
            failures++;
            $display("FAIL plru_victim: valid=%0b idx=%0d hit=%0b, required valid=1 idx=4 hit=0",
                     v, idx, h);
        end
        @(posedge clk);
        rd_idx8 = 3'd4;
        @(posedge clk);
        #1;
        checks++;
        if (rd8 !== 20'h00009) begin
            failures++;
            $display("FAIL read_victim: got %h, required 00009", rd8);
        end
        rd_idx8 = 3'd2;
        @(posedge clk);
        #1;
        checks++;
        if (rd8 !== 20'h00003) begin
            failures++;
            $display("FAIL read_hit_entry: got %h, required 00003", rd8);
        end
    endtask

    task automatic test_idle();
        @(posedge clk);
        #1;
        checks++;
        if ({v1_8, idx1_8, hit1_8} !== 5'd0) begin
            failures++;
            $display("FAIL idle: valid=%0b idx=%0d hit=%0b, required all 0", v1_8, idx1_8, hit1_8);
        end
    endtask

    task automatic test_back_to_back();
        logic       v, h;
        logic [2:0] idx;
        do_reset();
        drive8(32'hABCD_E000, v, idx, h);
        checks++;
        if ({v, idx, h} !== {1'b1, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_first: valid=%0b idx=%0d hit=%0b, required valid=1 idx=0 hit=0",
                     v, idx, h);
        end
        drive8(32'hABCD_E000, v, idx, h);
        checks++;
        if ({v, idx, h} !== {1'b1, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL b2b_second: valid=%0b idx=%0d hit=%0b, required valid=1 idx=0 hit=1",
                     v, idx, h);
        end
        @(posedge clk);
        #1;
        drive8(32'h1234_5000, v, idx, h);
        checks++;
        if ({v, idx, h} !== {1'b1, 3'd1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_no_dup: valid=%0b idx=%0d hit=%0b, required valid=1 idx=1 hit=0",
                     v, idx, h);
        end
    endtask

    task automatic test_read_bypass();
        logic       v, h;
        logic [2:0] idx;
        rd_idx8 = 3'd5;
        drive8(32'h2222_2000, v, idx, h);
        drive8(32'h3333_3000, v, idx, h);
        drive8(32'h4444_4000, v, idx, h);
        drive8(32'h5555_5000, v, idx, h);
        checks++;
        if ({v, idx, h} !== {1'b1, 3'd5, 1'b0}) begin
            failures++;
            $display("FAIL bypass_index: valid=%0b idx=%0d hit=%0b, required valid=1 idx=5 hit=0",
                     v, idx, h);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd8 !== 20'h55555) begin
            failures++;
            $display("FAIL read_bypass: got %h, required 55555", rd8);
        end
    endtask

    task automatic test_reset_mid_update();
        logic       v, h;
        logic [2:0] idx;
        do_reset();
        drive8(32'h7777_7000, v, idx, h);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        rd_idx8 = 3'd0;
        checks++;
        if ({v1_8, hit1_8} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset_valid: valid=%0b hit=%0b, required 0 0", v1_8, hit1_8);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd8 !== 20'h0) begin
            failures++;
            $display("FAIL mid_reset_dropped: got %h, required 00000", rd8);
        end
        drive8(32'h7777_7000, v, idx, h);
        checks++;
        if ({v, idx, h} !== {1'b1, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset_reinstall: valid=%0b idx=%0d hit=%0b, required valid=1 idx=0 hit=0",
                     v, idx, h);
        end
    endtask

    task automatic test_sixteen();
        logic       v, h;
        logic [3:0] idx;
        int         bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            drive16(32'(i + 'h100) << 12, v, idx, h);
            if ({v, idx, h} !== {1'b1, 4'(i), 1'b0}) begin
                bad++;
                $display("FAIL fill16[%0d]: valid=%0b idx=%0d hit=%0b, required valid=1 idx=%0d hit=0",
                         i, v, idx, h, i);
            end
        end
        checks++;
        if (bad != 0) failures++;
        drive16(32'hFEDC_B000, v, idx, h);
        checks++;
        if ({v, idx, h} !== {1'b1, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL victim16: valid=%0b idx=%0d hit=%0b, required valid=1 idx=0 hit=0",
                     v, idx, h);
        end
        rd_idx16 = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (rd16 !== 20'hFEDCB) begin
            failures++;
            $display("FAIL read16: got %h, required FEDCB", rd16);
        end
    endtask

`ifdef UPCT_PERF_CNT_EN
    task automatic test_perf();
        logic       v, h;
        logic [2:0] idx;
        do_reset();
        drive8(32'h0001_0000, v, idx, h);
        drive8(32'h0002_0000, v, idx, h);
        drive8(32'h0003_0000, v, idx, h);
        drive8(32'h0001_0000, v, idx, h);
        drive8(32'h0002_0000, v, idx, h);
        @(posedge clk);
        #1;
        checks++;
        if ({pmiss8, phit8} !== {32'd3, 32'd2}) begin
            failures++;
            $display("FAIL perf_counts: miss=%0d hit=%0d, required miss=3 hit=2", pmiss8, phit8);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({pmiss8, phit8} !== 64'd0) begin
            failures++;
            $display("FAIL perf_reset: miss=%0d hit=%0d, required 0 0", pmiss8, phit8);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fill_and_plru();
        test_idle();
        test_back_to_back();
        test_read_bypass();
        test_reset_mid_update();
        test_sixteen();
`ifdef UPCT_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
